controle_ula: RTL and testbench



---
 rtl/ula_pkg.sv | 34 +++
 rtl/ula_flags_gen.sv | 38 +++
 rtl/controle_ula.sv | 121 ++++++++++++
 tb/tb_controle_ula.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM encoding and flag layout.
package ula_pkg;

  localparam logic [2:0] OP_SOMA = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MULT = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } ula_state_t;

  localparam int FLG_Z    = 0;
  localparam int FLG_C    = 1;
  localparam int FLG_V    = 2;
  localparam int FLG_N    = 3;
  localparam int FLG_SAT  = 4;
  localparam int FLG_DIV0 = 5;
  localparam int FLG_ERR  = 6;

  localparam int FLAG_W = 7;

  // Flag word of a timeout capture: only ERR survives.
  localparam logic [FLAG_W-1:0] FLAGS_TIMEOUT = 7'b1000000;

endpackage

// File: rtl/ula_flags_gen.sv
// Combinational flag derivation from the ALU outputs; ERR is added by the sequencer.
module ula_flags_gen
  import ula_pkg::*;
(
  input  logic [2:0] sel,
  input  logic [7:0] b,
  input  logic       soma_cout,
  input  logic       soma_c7,
  input  logic       sub_bout,
  input  logic       sub_b7,
  input  logic       multi_sat,
  input  logic [7:0] ula_s,
  input  logic [7:0] ula_ss,
  output logic [5:0] flags
);

  always_comb begin
    flags           = '0;
    flags[FLG_Z]    = (ula_ss == 8'd0);
    flags[FLG_N]    = ula_s[7];
    flags[FLG_DIV0] = (sel == OP_DIV) && (b == 8'd0);
    case (sel)
      OP_SOMA: begin
        flags[FLG_C]   = soma_cout;
        flags[FLG_V]   = soma_cout ^ soma_c7;
        flags[FLG_SAT] = (ula_ss != ula_s);
      end
      OP_SUB: begin
        flags[FLG_C]   = sub_bout;
        flags[FLG_V]   = sub_bout ^ sub_b7;
        flags[FLG_SAT] = (ula_ss != ula_s);
      end
      OP_MULT: flags[FLG_SAT] = multi_sat;
      default: ;
    endcase
  end

endmodule

// File: rtl/controle_ula.sv
// Command sequencer for the 8-bit ALU: latches operands, pulses start, waits for
// ula_pronto (or times out) and holds the captured result until consumed.
//
//  state  | meaning
//  IDLE   | ready for a command; operands latched on acceptance
//  LOAD   | ula_start high for this single cycle
//  SETTLE | ula_pronto ignored (may be stale), timeout counter cleared
//  WAIT   | capture on ula_pronto, or forced ERR capture at TIMEOUT
//  DONE   | res_valid high until res_ready
module controle_ula
  import ula_pkg::*;
#(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_a,
  input  logic [7:0]        cmd_b,
  input  logic [2:0]        cmd_sel,
  output logic [7:0]        ula_a,
  output logic [7:0]        ula_b,
  output logic [2:0]        ula_sel,
  output logic              ula_start,
  input  logic [7:0]        ula_s,
  input  logic [7:0]        ula_ss,
  input  logic [7:0]        ula_resto,
  input  logic              soma_cout,
  input  logic              soma_c7,
  input  logic              sub_bout,
  input  logic              sub_b7,
  input  logic              multi_sat,
  input  logic              ula_pronto,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_val,
  output logic [7:0]        res_resto,
  output logic [FLAG_W-1:0] res_flags
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  ula_state_t state;
  logic [7:0] wait_cnt;
  logic [5:0] flags;

  ula_flags_gen u_flags (
    .sel       (ula_sel),
    .b         (ula_b),
    .soma_cout (soma_cout),
    .soma_c7   (soma_c7),
    .sub_bout  (sub_bout),
    .sub_b7    (sub_b7),
    .multi_sat (multi_sat),
    .ula_s     (ula_s),
    .ula_ss    (ula_ss),
    .flags     (flags)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      cmd_ready <= 1'b1;
      ula_a     <= '0;
      ula_b     <= '0;
      ula_sel   <= '0;
      ula_start <= 1'b0;
      res_valid <= 1'b0;
      res_val   <= '0;
      res_resto <= '0;
      res_flags <= '0;
    end else begin
      ula_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            ula_a     <= cmd_a;
            ula_b     <= cmd_b;
            ula_sel   <= cmd_sel;
            ula_start <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_SETTLE;
        ST_SETTLE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ula_pronto) begin
            res_val   <= ula_ss;
            res_resto <= ula_resto;
            res_flags <= {1'b0, flags};
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            res_val   <= ula_ss;
            res_resto <= ula_resto;
            res_flags <= FLAGS_TIMEOUT;
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_ula.sv
// Directed-vector bench for controle_ula with a hand-driven ALU.
module tb_controle_ula;
  import ula_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_sel;
  logic [7:0] ula_a, ula_b;
  logic [2:0] ula_sel;
  logic       ula_start;
  logic [7:0] ula_s, ula_ss, ula_resto;
  logic       soma_cout, soma_c7, sub_bout, sub_b7, multi_sat;
  logic       ula_pronto;
  logic       res_valid, res_ready;
  logic [7:0] res_val, res_resto;
  logic [6:0] res_flags;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int n_bad;

  controle_ula #(.TIMEOUT(31)) dut (
    .Clk(Clk), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .ula_a(ula_a), .ula_b(ula_b), .ula_sel(ula_sel), .ula_start(ula_start),
    .ula_s(ula_s), .ula_ss(ula_ss), .ula_resto(ula_resto),
    .soma_cout(soma_cout), .soma_c7(soma_c7), .sub_bout(sub_bout), .sub_b7(sub_b7),
    .multi_sat(multi_sat), .ula_pronto(ula_pronto),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_val(res_val), .res_resto(res_resto), .res_flags(res_flags)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic set_alu(input logic [7:0] s, input logic [7:0] ss, input logic [7:0] resto,
                         input logic [4:0] src, input logic pronto);
    ula_s = s; ula_ss = ss; ula_resto = resto;
    {soma_cout, soma_c7, sub_bout, sub_b7, multi_sat} = src;
    ula_pronto = pronto;
  endtask

  // Returns after the acceptance edge (E0) plus #1.
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(input int max_cyc, output int latency);
    latency = -1;
    for (int i = 1; i <= max_cyc && latency < 0; i++) begin
      @(posedge Clk); #1;
      if (res_valid) latency = i;
    end
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(posedge Clk); #1;
    res_ready = 1'b0;
    check_val({tag, "_cmd_ready_after"}, cmd_ready, 1);
    check_val({tag, "_res_valid_after"}, res_valid, 0);
  endtask

  initial begin
    Reset = 1'b1; cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_sel = 0; res_ready = 0;
    set_alu(8'd0, 8'd0, 8'd0, 5'b00000, 1'b0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    check_val("rst_cmd_ready", cmd_ready, 1);
    check_val("rst_res_valid", res_valid, 0);
    check_val("rst_ula_start", ula_start, 0);
    check_val("rst_operands", {ula_a, ula_b, 5'(ula_sel)}, 0);
    check_val("rst_results", {res_val, res_resto, 1'b0, res_flags}, 0);

    // SOMA 200+100 saturating
    set_alu(8'd44, 8'd0, 8'd0, 5'b11000, 1'b1);
    send_cmd(8'd200, 8'd100, OP_SOMA);
    check_val("soma_start", ula_start, 1);
    check_val("soma_ula_a", ula_a, 200);
    check_val("soma_ula_b", ula_b, 100);
    check_val("soma_cmd_ready", cmd_ready, 0);
    wait_result(10, lat);
    check_val("soma_latency", lat, 3);
    check_val("soma_val", res_val, 0);
    check_val("soma_flags", res_flags, 7'b0010011);
    consume("soma");

    // SUB 5-10 underflow
    set_alu(8'd251, 8'd0, 8'd0, 5'b00110, 1'b1);
    send_cmd(8'd5, 8'd10, OP_SUB);
    wait_result(10, lat);
    check_val("sub_latency", lat, 3);
    check_val("sub_flags", res_flags, 7'b0011011);
    consume("sub");

    // AND with all flag sources high: C/V/SAT must stay clear
    set_alu(8'h0C, 8'h0C, 8'd0, 5'b11111, 1'b1);
    send_cmd(8'h3C, 8'h0F, OP_AND);
    wait_result(10, lat);
    check_val("and_latency", lat, 3);
    check_val("and_val", res_val, 8'h0C);
    check_val("and_flags", res_flags, 7'b0000000);
    consume("and");

    // MULT with stale pronto held through SETTLE, real pronto 8 cycles into WAIT
    set_alu(8'd255, 8'd255, 8'd0, 5'b10001, 1'b1);
    send_cmd(8'd20, 8'd20, OP_MULT);
    check_val("mult_start_pulse", ula_start, 1);
    @(posedge Clk); #1;
    check_val("mult_start_drop", ula_start, 0);
    cmd_valid = 1'b1; cmd_a = 8'd77;
    @(posedge Clk); #1;
    ula_pronto = 1'b0;
    cmd_valid = 1'b0;
    n_bad = res_valid ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      if (res_valid) n_bad++;
    end
    check_val("mult_early_capture", n_bad, 0);
    check_val("mult_ignored_cmd", ula_a, 20);
    ula_pronto = 1'b1;
    @(posedge Clk); #1;
    check_val("mult_latency11", res_valid, 1);
    check_val("mult_val", res_val, 255);
    check_val("mult_flags", res_flags, 7'b0011000);
    consume("mult");

    // Timeout
    set_alu(8'd0, 8'd0, 8'd0, 5'b00001, 1'b0);
    send_cmd(8'd3, 8'd4, OP_MULT);
    wait_result(60, lat);
    check_val("timeout_latency", lat, 34);
    check_val("timeout_flags", res_flags, 7'b1000000);
    consume("timeout");

    // DIV0 with back-pressure
    set_alu(8'd255, 8'd255, 8'd9, 5'b00000, 1'b1);
    send_cmd(8'd9, 8'd0, OP_DIV);
    wait_result(10, lat);
    check_val("div0_latency", lat, 3);
    check_val("div0_flags", res_flags, 7'b0101000);
    check_val("div0_resto", res_resto, 9);
    n_bad = 0;
    cmd_valid = 1'b1; cmd_a = 8'd55;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      if (!res_valid || cmd_ready || res_val != 8'd255 || res_resto != 8'd9 ||
          res_flags != 7'b0101000 || ula_a != 8'd9) n_bad++;
    end
    cmd_valid = 1'b0;
    check_val("bp_hold", n_bad, 0);
    consume("div0");

    // Reset during LOAD drops ula_start
    set_alu(8'd0, 8'd0, 8'd0, 5'b00000, 1'b0);
    send_cmd(8'd1, 8'd2, OP_MULT);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check_val("rst_load_start", ula_start, 0);
    check_val("rst_load_ready", cmd_ready, 1);

    // Reset mid-WAIT; res_ready outside DONE is ignored
    send_cmd(8'd1, 8'd2, OP_MULT);
    res_ready = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    check_val("wait_res_ready_ignored", cmd_ready, 0);
    res_ready = 1'b0;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check_val("rst_wait_res_valid", res_valid, 0);
    check_val("rst_wait_start", ula_start, 0);
    check_val("rst_wait_ready", cmd_ready, 1);
    check_val("rst_wait_results", {res_val, res_resto, 1'b0, res_flags}, 0);

    set_alu(8'd7, 8'd7, 8'd0, 5'b00000, 1'b1);
    send_cmd(8'd3, 8'd4, OP_SOMA);
    wait_result(10, lat);
    check_val("post_rst_latency", lat, 3);
    check_val("post_rst_val", res_val, 7);
    check_val("post_rst_flags", res_flags, 7'b0000000);
    consume("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
